// File: rtl/johnson_phase_decoder_pkg.sv
// Shared constants and code helpers for Johnson (twisted-ring) counter
// decoding. The helpers work on a fixed maximum width so that any decoder
// width up to CW_MAX can use them.
package johnson_phase_decoder_pkg;

   localparam int N_DEF  = 2;
   localparam int CW_MAX = 16;
   localparam int KW_MAX = 8;

   typedef struct packed {
      logic              legal;
      logic [KW_MAX-1:0] k;
   } jidx_t;

   // Number of phases of an n-bit Johnson counter.
   function automatic int phase_count(input int n);
      return 2 * n;
   endfunction

   // Width of a binary phase index for an n-bit Johnson counter.
   function automatic int index_width(input int n);
      return $clog2(2 * n);
   endfunction

   // Johnson code for phase k: k ones filling from bit 0, then k-n zeros
   // filling from bit 0.
   function automatic logic [CW_MAX-1:0] johnson_code(input int k, input int n);
      logic [31:0] v;
      if (k <= n)
         v = (32'd1 << k) - 32'd1;
      else
         v = ~((32'd1 << (k - n)) - 32'd1) & ((32'd1 << n) - 32'd1);
      return v[CW_MAX-1:0];
   endfunction

   // Map a code to {legal, k}; k is 0 when the code is illegal.
   function automatic jidx_t johnson_index(input logic [CW_MAX-1:0] code, input int n);
      jidx_t r;
      r = '0;
      for (int k = 0; k < 2 * CW_MAX; k++) begin
         if ((k < 2 * n) && (code == johnson_code(k, n))) begin
            r.legal = 1'b1;
            r.k     = KW_MAX'(k);
         end
      end
      return r;
   endfunction

   // Successor phase, wrapping at p.
   function automatic logic [KW_MAX-1:0] next_phase(input logic [KW_MAX-1:0] k, input int p);
      logic [KW_MAX-1:0] r;
      if (int'(k) >= p - 1)
         r = '0;
      else
         r = k + 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/johnson_phase_if.sv
// Sample/decode bundle between the ring-counter consumer logic and the decoder.
interface johnson_phase_if
   import johnson_phase_decoder_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int RW = 8
);
   localparam int P  = phase_count(N);
   localparam int IW = index_width(N);

   logic          EN;
   logic          CLR;
   logic [N-1:0]  J;
   logic [P-1:0]  PHASE;
   logic [IW-1:0] IDX;
   logic          VALID;
   logic          STEP_ERR;
   logic          ERR;
   logic [RW-1:0] REV;

   modport master (output EN, CLR, J, input PHASE, IDX, VALID, STEP_ERR, ERR, REV);
   modport slave  (input EN, CLR, J, output PHASE, IDX, VALID, STEP_ERR, ERR, REV);
endinterface

// File: rtl/johnson_phase_decoder_code_check.sv
// Combinational Johnson code classifier: J -> {legal, phase index}.
// Also used by the ring-counter self-test.
module johnson_code_check
   import johnson_phase_decoder_pkg::*;
#(
   parameter int N = N_DEF
)(
   input  logic [N-1:0]              J,
   output logic                      legal,
   output logic [index_width(N)-1:0] k
);
   localparam int IW = index_width(N);

   jidx_t res;

   // Decode against every legal pattern of this width.
   assign res   = johnson_index(CW_MAX'(J), N);
   assign legal = res.legal;
   assign k     = res.k[IW-1:0];

endmodule

// File: rtl/johnson_phase_decoder.sv
// Registered phase decoder and sequence checker for an N-bit Johnson counter.
// Produces a one-hot phase, binary index and revolution count, and flags
// illegal codes and non-adjacent steps.
//
// Sequencing flags (no explicit FSM):
//   sync | meaning
//   0    | no trusted previous phase; next legal code is accepted unchecked
//   1    | IDX holds a trusted phase; next code is step-checked against it
module johnson_phase_decoder
   import johnson_phase_decoder_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int RW = 8
)(
   input  logic            CLK,
   input  logic            RESET,
   johnson_phase_if.slave  bus
);
   localparam int P  = phase_count(N);
   localparam int IW = index_width(N);

   logic          legal;
   logic [IW-1:0] k;

   logic [P-1:0]  phase_q, phase_n;
   logic [IW-1:0] idx_q, idx_n;
   logic          valid_q, valid_n;
   logic          step_err_q, step_err_n;
   logic          err_q, err_n;
   logic [RW-1:0] rev_q, rev_n;
   logic          sync_q, sync_n;
   logic          new_err;

   johnson_code_check #(.N(N)) u_check (
      .J     (bus.J),
      .legal (legal),
      .k     (k)
   );

   // Next-state: decode the sample, step-check it and update counters.
   always_comb begin
      phase_n = phase_q;
      idx_n   = idx_q;
      valid_n = valid_q;
      rev_n   = rev_q;
      sync_n  = sync_q;
      new_err = 1'b0;
      if (bus.EN) begin
         if (legal) begin
            phase_n = P'(1) << k;
            idx_n   = k;
            valid_n = 1'b1;
            sync_n  = 1'b1;
            if (sync_q && (k != idx_q)) begin
               if (KW_MAX'(k) == next_phase(KW_MAX'(idx_q), P)) begin
                  if (idx_q == IW'(P - 1))
                     rev_n = rev_q + RW'(1);
               end else begin
                  new_err = 1'b1;
               end
            end
         end else begin
            phase_n = '0;
            valid_n = 1'b0;
            sync_n  = 1'b0;
            new_err = 1'b1;
         end
      end
      step_err_n = new_err;
      // A new error outranks a clear in the same cycle.
      if (new_err)
         err_n = 1'b1;
      else if (bus.CLR)
         err_n = 1'b0;
      else
         err_n = err_q;
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         phase_q    <= '0;
         idx_q      <= '0;
         valid_q    <= 1'b0;
         step_err_q <= 1'b0;
         err_q      <= 1'b0;
         rev_q      <= '0;
         sync_q     <= 1'b0;
      end else begin
         phase_q    <= phase_n;
         idx_q      <= idx_n;
         valid_q    <= valid_n;
         step_err_q <= step_err_n;
         err_q      <= err_n;
         rev_q      <= rev_n;
         sync_q     <= sync_n;
      end
   end

   assign bus.PHASE    = phase_q;
   assign bus.IDX      = idx_q;
   assign bus.VALID    = valid_q;
   assign bus.STEP_ERR = step_err_q;
   assign bus.ERR      = err_q;
   assign bus.REV      = rev_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Scoreboard bench for johnson_phase_decoder: N=2 and N=3 instances.
// Stimulus is applied on the falling edge and pushes the expected response;
// the monitor pops one entry per cycle just after the rising edge.
module tb_johnson_phase_decoder;

   logic clk;
   logic rst2, rst3;

   johnson_phase_if #(.N(2), .RW(8)) if2 ();
   johnson_phase_if #(.N(3), .RW(8)) if3 ();

   johnson_phase_decoder #(.N(2), .RW(8)) dut2 (.CLK(clk), .RESET(rst2), .bus(if2));
   johnson_phase_decoder #(.N(3), .RW(8)) dut3 (.CLK(clk), .RESET(rst3), .bus(if3));

   typedef struct {
      int         dut;
      logic [5:0] phase;
      logic [2:0] idx;
      logic       valid;
      logic       step;
      logic       err;
      logic [7:0] rev;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: compare the registered outputs against the oldest expectation.
   initial begin
      exp_t       e;
      logic [5:0] a_phase;
      logic [2:0] a_idx;
      logic       a_valid, a_step, a_err;
      logic [7:0] a_rev;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 2) begin
               a_phase = {2'b00, if2.PHASE};
               a_idx   = {1'b0, if2.IDX};
               a_valid = if2.VALID;
               a_step  = if2.STEP_ERR;
               a_err   = if2.ERR;
               a_rev   = if2.REV;
            end else begin
               a_phase = if3.PHASE;
               a_idx   = if3.IDX;
               a_valid = if3.VALID;
               a_step  = if3.STEP_ERR;
               a_err   = if3.ERR;
               a_rev   = if3.REV;
            end
            n_cmp++;
            if (a_phase !== e.phase || a_idx !== e.idx || a_valid !== e.valid ||
                a_step !== e.step || a_err !== e.err || a_rev !== e.rev) begin
               n_fail++;
               $display("FAIL %s dut%0d: got phase=%b idx=%0d valid=%b step=%b err=%b rev=%0d, want phase=%b idx=%0d valid=%b step=%b err=%b rev=%0d",
                        e.name, e.dut, a_phase, a_idx, a_valid, a_step, a_err, a_rev,
                        e.phase, e.idx, e.valid, e.step, e.err, e.rev);
            end
         end
      end
   end

   task automatic push(input int dut, input logic [5:0] phase, input logic [2:0] idx,
                       input logic valid, input logic step, input logic err,
                       input logic [7:0] rev, input string name);
      exp_t e;
      e.dut = dut; e.phase = phase; e.idx = idx; e.valid = valid;
      e.step = step; e.err = err; e.rev = rev; e.name = name;
      sb.push_back(e);
   endtask

   task automatic s2(input logic r, input logic en, input logic clr, input logic [1:0] j,
                     input logic [3:0] phase, input logic [1:0] idx, input logic valid,
                     input logic step, input logic err, input logic [7:0] rev, input string name);
      rst2 = r; if2.EN = en; if2.CLR = clr; if2.J = j;
      push(2, {2'b00, phase}, {1'b0, idx}, valid, step, err, rev, name);
      @(negedge clk);
   endtask

   task automatic s3(input logic r, input logic en, input logic clr, input logic [2:0] j,
                     input logic [5:0] phase, input logic [2:0] idx, input logic valid,
                     input logic step, input logic err, input logic [7:0] rev, input string name);
      rst3 = r; if3.EN = en; if3.CLR = clr; if3.J = j;
      push(3, phase, idx, valid, step, err, rev, name);
      @(negedge clk);
   endtask

   logic [1:0] seq2 [4];
   logic [1:0] rot_code [4];
   logic [1:0] rot_idx  [4];
   logic [7:0] rv;

   initial begin
      seq2[0] = 2'b00; seq2[1] = 2'b01; seq2[2] = 2'b11; seq2[3] = 2'b10;
      rst2 = 1'b1; rst3 = 1'b1;
      if2.EN = 1'b0; if2.CLR = 1'b0; if2.J = 2'b00;
      if3.EN = 1'b0; if3.CLR = 1'b0; if3.J = 3'b000;
      @(negedge clk);

      // 1. reset with J=01 and EN=1: all outputs zero
      s2(1, 1, 0, 2'b01, 4'b0000, 0, 0, 0, 0, 0, "reset_a");
      s2(1, 1, 0, 2'b01, 4'b0000, 0, 0, 0, 0, 0, "reset_b");

      // 2. 20 cycles of 00,01,11,10; first sample syncs, then four 3->0 wraps
      for (int i = 0; i < 20; i++)
         s2(0, 1, 0, seq2[i % 4], 4'(1 << (i % 4)), 2'(i % 4), 1, 0, 0, 8'(i / 4),
            (i == 0) ? "first_after_reset" : "rotation");

      // 3. skip 1 -> 3, then 3 -> 0 still counts a revolution
      s2(0, 1, 0, 2'b00, 4'b0001, 0, 1, 0, 0, 5, "wrap_to_0");
      s2(0, 1, 0, 2'b01, 4'b0010, 1, 1, 0, 0, 5, "at_idx1");
      s2(0, 1, 0, 2'b10, 4'b1000, 3, 1, 1, 1, 5, "skip_step_err");
      s2(0, 1, 0, 2'b00, 4'b0001, 0, 1, 0, 1, 6, "after_skip_rev");

      // 5. EN gating and CLR priority
      s2(0, 0, 0, 2'b11, 4'b0001, 0, 1, 0, 1, 6, "en0_hold");
      s2(0, 0, 1, 2'b11, 4'b0001, 0, 1, 0, 0, 6, "clr_while_en0");
      s2(0, 1, 1, 2'b01, 4'b0010, 1, 1, 0, 0, 6, "clr_no_err");
      s2(0, 1, 1, 2'b00, 4'b0001, 0, 1, 1, 1, 6, "clr_vs_backstep");
      s2(0, 1, 0, 2'b01, 4'b0010, 1, 1, 0, 1, 6, "err_sticky");
      s2(0, 1, 1, 2'b01, 4'b0010, 1, 1, 0, 0, 6, "clr_hold_code");

      // 6. rotate from REV=6 through 255 to the wrap at 0
      rot_code[0] = 2'b11; rot_code[1] = 2'b10; rot_code[2] = 2'b00; rot_code[3] = 2'b01;
      rot_idx[0]  = 2'd2;  rot_idx[1]  = 2'd3;  rot_idx[2]  = 2'd0;  rot_idx[3]  = 2'd1;
      rv = 8'd6;
      for (int r = 0; r < 250; r++) begin
         for (int p = 0; p < 4; p++) begin
            if (p == 2) rv = rv + 8'd1;
            s2(0, 1, 0, rot_code[p], 4'(1 << rot_idx[p]), rot_idx[p], 1, 0, 0, rv,
               (r == 249 && p == 2) ? "rev_wrap_0" : ((r == 248 && p == 2) ? "rev_255" : "long_rotation"));
         end
      end
      s2(0, 1, 0, 2'b11, 4'b0100, 2, 1, 0, 0, 0, "mid_idx2");
      s2(1, 1, 0, 2'b10, 4'b0000, 0, 0, 0, 0, 0, "mid_reset");
      s2(0, 1, 0, 2'b10, 4'b1000, 3, 1, 0, 0, 0, "resync_after_reset");
      s2(0, 1, 0, 2'b00, 4'b0001, 0, 1, 0, 0, 1, "rev_after_resync");
      if2.EN = 1'b0;

      // 4. N=3: illegal code 101 at idx 2, then resync at 111
      s3(1, 0, 0, 3'b000, 6'b000000, 0, 0, 0, 0, 0, "n3_reset");
      s3(0, 1, 0, 3'b000, 6'b000001, 0, 1, 0, 0, 0, "n3_k0");
      s3(0, 1, 0, 3'b001, 6'b000010, 1, 1, 0, 0, 0, "n3_k1");
      s3(0, 1, 0, 3'b011, 6'b000100, 2, 1, 0, 0, 0, "n3_k2");
      s3(0, 1, 0, 3'b101, 6'b000000, 2, 0, 1, 1, 0, "n3_illegal");
      s3(0, 1, 0, 3'b111, 6'b001000, 3, 1, 0, 1, 0, "n3_resync");
      s3(0, 1, 0, 3'b110, 6'b010000, 4, 1, 0, 1, 0, "n3_k4");
      s3(0, 1, 0, 3'b100, 6'b100000, 5, 1, 0, 1, 0, "n3_k5");
      s3(0, 1, 0, 3'b000, 6'b000001, 0, 1, 0, 1, 1, "n3_rev");
      s3(0, 1, 0, 3'b010, 6'b000000, 0, 0, 1, 1, 1, "n3_illegal_010");
      if3.EN = 1'b0;

      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
